sweep_chk: RTL

Synthesizable sweep-and-check controller that lives inside the emulator next to a DUT. It steps a fixed-point stimulus across a programmed range, one value per settle window. For each value it samples the DUT output against an expected value and accumulates the squared error. At the end it issues a pass/fail verdict against a mean-squared-error tolerance. The host only pulses `start` and reads `done`/`pass`, so the whole sweep runs at emulator speed instead of being driven from the host one cycle at a time.

---
 rtl/sweep_chk.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sweep_chk.sv
// sweep_chk: on-emulator sweep-and-check controller.
//
// Steps a signed fixed-point stimulus from START towards STOP in STEP
// increments. Each value is held for SETTLE_CYC cycles. The DUT response is
// then compared with the reference model's expected value, and the squared
// error is accumulated. At the end a pass/fail verdict is produced against a
// mean-squared-error tolerance, without any division.
//
// Ports:
//   emu_clk     in   1          emulator clock
//   emu_rst_n   in   1          asynchronous active-low reset
//   start       in   1          one-cycle sweep request (ignored while busy)
//   in_         out  WIDTH      stimulus to the DUT (signed)
//   out         in   WIDTH      DUT response (signed)
//   expct       in   WIDTH      expected response for current in_ (signed)
//   busy        out  1          sweep in progress
//   done        out  1          verdict valid
//   pass        out  1          verdict, meaningful while done=1
//   n_samp      out  CNT_WIDTH  samples accumulated (saturating)
//   sum_err_sq  out  ACC_WIDTH  accumulated squared error (saturating)
module sweep_chk #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int START      = -768,
  parameter int STOP       = 768,
  parameter int STEP       = 64,
  parameter int SETTLE_CYC = 1,
  parameter int ACC_WIDTH  = 48,
  parameter int CNT_WIDTH  = 16,
  parameter int TOL_SQ     = 1
) (
  input  logic                        emu_clk,
  input  logic                        emu_rst_n,
  input  logic                        start,
  output logic signed [WIDTH-1:0]     in_,
  input  logic signed [WIDTH-1:0]     out,
  input  logic signed [WIDTH-1:0]     expct,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CNT_WIDTH-1:0]        n_samp,
  output logic [ACC_WIDTH-1:0]        sum_err_sq
);

  // Elaboration-time parameter sanity checks.
  if (STEP <= 0) begin : g_bad_step
    $error("sweep_chk: STEP must be greater than zero");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("sweep_chk: SETTLE_CYC must be at least one");
  end

  localparam int DIFF_W = WIDTH + 1;
  localparam int PROD_W = 2 * DIFF_W;
  // Accumulation is done one bit wider than the larger operand so a carry
  // out of ACC_WIDTH can be detected and turned into saturation.
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
  // Tolerance product TOL_SQ * n_samp is formed at full precision.
  localparam int MUL_W  = 32 + CNT_WIDTH;
  localparam int CMP_W  = ((ACC_WIDTH > MUL_W) ? ACC_WIDTH : MUL_W) + 1;
  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic signed [WIDTH-1:0] START_W  = WIDTH'(START);
  localparam logic signed [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH:0]   MAXPOS_W = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [SET_W-1:0]        SET_INIT = SET_W'(SETTLE_CYC - 1);
  localparam logic [31:0]             TOL_U    = 32'(TOL_SQ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_ACC    = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  in_q, in_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [CNT_WIDTH-1:0]     n_q, n_d;
  logic [ACC_WIDTH-1:0]     sum_q, sum_d;
  logic [PROD_W-1:0]        sq_q, sq_d;
  logic [SET_W-1:0]         set_q, set_d;

  logic signed [DIFF_W-1:0] diff_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        sq_s;
  logic [SUM_W-1:0]         sum_ext_s;
  logic                     sum_sat_s;
  logic signed [WIDTH:0]    next_s;
  int                       next_i;
  logic                     stop_hit_s;
  logic [CMP_W-1:0]         tol_lim_s;
  logic                     pass_now_s;

  // Error path: diff is one bit wider than the operands so expct-out can
  // never wrap; its square is always non-negative, so it is reinterpreted
  // as unsigned before the fractional shift.
  assign diff_s = {expct[WIDTH-1], expct} - {out[WIDTH-1], out};
  assign prod_s = diff_s * diff_s;
  assign sq_s   = $unsigned(prod_s) >> FRAC;

  assign sum_ext_s = SUM_W'(sum_q) + SUM_W'(sq_q);
  assign sum_sat_s = |sum_ext_s[SUM_W-1:ACC_WIDTH];

  // Next stimulus at WIDTH+1 bits: values above the signed WIDTH range
  // end the sweep instead of wrapping to a negative stimulus.
  assign next_s     = {in_q[WIDTH-1], in_q} + STEP_W;
  assign next_i     = int'(next_s);
  assign stop_hit_s = (next_i > STOP) || (next_s > MAXPOS_W);

  // Mean-square check without division: sum <= TOL_SQ * n.
  assign tol_lim_s  = CMP_W'(TOL_U) * CMP_W'(n_q);
  assign pass_now_s = (CMP_W'(sum_q) <= tol_lim_s);

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    n_d     = n_q;
    sum_d   = sum_q;
    sq_d    = sq_q;
    set_d   = set_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          in_d    = START_W;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          n_d     = {CNT_WIDTH{1'b0}};
          sum_d   = {ACC_WIDTH{1'b0}};
          set_d   = SET_INIT;
        end else begin
          state_d = state_q;
        end
      end
      S_SETTLE: begin
        if (set_q == {SET_W{1'b0}}) begin
          state_d = S_SAMPLE;
        end else begin
          set_d = set_q - SET_W'(1'b1);
        end
      end
      S_SAMPLE: begin
        sq_d    = sq_s;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (sum_sat_s) begin
          sum_d = {ACC_WIDTH{1'b1}};
        end else begin
          sum_d = sum_ext_s[ACC_WIDTH-1:0];
        end
        if (n_q == {CNT_WIDTH{1'b1}}) begin
          n_d = n_q;
        end else begin
          n_d = n_q + CNT_WIDTH'(1'b1);
        end
        if (stop_hit_s) begin
          state_d = S_CHECK;
        end else begin
          in_d    = next_s[WIDTH-1:0];
          set_d   = SET_INIT;
          state_d = S_SETTLE;
        end
      end
      S_CHECK: begin
        pass_d  = pass_now_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q <= S_IDLE;
      in_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      n_q     <= {CNT_WIDTH{1'b0}};
      sum_q   <= {ACC_WIDTH{1'b0}};
      sq_q    <= {PROD_W{1'b0}};
      set_q   <= {SET_W{1'b0}};
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      sq_q    <= sq_d;
      set_q   <= set_d;
    end
  end

  assign in_        = in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign n_samp     = n_q;
  assign sum_err_sq = sum_q;

endmodule
